// File: rtl/trellis_cfg_pkg.sv
// Shared types for the trellis injection configuration sequencer.
package trellis_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    SETTLE = 2'd2,
    READY  = 2'd3
  } state_t;

  localparam logic [1:0] SEL_CHANNEL = 2'd0;
  localparam logic [1:0] SEL_PATTERN = 2'd1;
  localparam logic [1:0] SEL_NRZ     = 2'd2;

endpackage

// File: rtl/trellis_cfg_regbank.sv
// Shadow/active register pair: indexed writes land in the shadow copy,
// a swap strobe moves the whole shadow copy into the active copy at once.
module trellis_cfg_regbank #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic signed [WIDTH-1:0] wr_data,
  input  logic                    swap,
  output logic signed [WIDTH-1:0] active [DEPTH]
);

  logic signed [WIDTH-1:0] shadow [DEPTH];

  // Indexed shadow write; the caller has already range-checked the address.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++) shadow[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_en && wr_addr == AW'(i)) shadow[i] <= wr_data;
    end
  end

  // Bulk copy of the shadow bank into the active bank on swap.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++) active[i] <= '0;
    end else if (swap) begin
      active <= shadow;
    end
  end

endmodule

// File: rtl/trellis_injection_cfg_ctrl.sv
// Configuration sequencer for the trellis error-injection datapath:
// shadow writes, frame-aligned commit, settle window, then seqs_valid.
module trellis_injection_cfg_ctrl
  import trellis_cfg_pkg::*;
#(
  parameter int seq_length              = 3,
  parameter int trellis_pattern_depth   = 3,
  parameter int num_of_trellis_patterns = 3,
  parameter int branch_bitwidth         = 2,
  parameter int est_channel_bitwidth    = 8,
  parameter int settle_cycles           = 2,
  parameter int addr_bitwidth = $clog2(
    ((seq_length + trellis_pattern_depth - 1) > (num_of_trellis_patterns * trellis_pattern_depth)) ?
     (seq_length + trellis_pattern_depth - 1) : (num_of_trellis_patterns * trellis_pattern_depth))
) (
  input  logic                                   clk,
  input  logic                                   rstb,
  input  logic                                   cfg_wr_en,
  input  logic [1:0]                             cfg_sel,
  input  logic [addr_bitwidth-1:0]               cfg_addr,
  input  logic signed [est_channel_bitwidth-1:0] cfg_data,
  input  logic                                   commit_req,
  input  logic                                   frame_sync,
  output logic                                   commit_ack,
  output logic signed [est_channel_bitwidth-1:0] channel [seq_length+trellis_pattern_depth-1],
  output logic signed [branch_bitwidth-1:0]      trellis_patterns [num_of_trellis_patterns][trellis_pattern_depth],
  output logic                                   nrz_mode,
  output logic                                   seqs_valid,
  output logic                                   busy,
  output logic                                   cfg_err
);

  localparam int CH_D  = seq_length + trellis_pattern_depth - 1;
  localparam int PT_N  = num_of_trellis_patterns * trellis_pattern_depth;
  localparam int CNT_W = (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
  localparam logic [31:0] CH_D_U = CH_D;
  localparam logic [31:0] PT_N_U = PT_N;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               commit_ack_d, seqs_valid_d, cfg_err_d;
  logic               swap, ch_wr, pt_wr, nrz_wr;
  logic               nrz_shadow;
  logic [31:0]        addr_ext;
  logic signed [branch_bitwidth-1:0] pt_active [PT_N];

  trellis_cfg_regbank #(.DEPTH(CH_D), .WIDTH(est_channel_bitwidth), .AW(addr_bitwidth)) u_ch_bank (
    .clk     (clk),
    .rstb    (rstb),
    .wr_en   (ch_wr),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data),
    .swap    (swap),
    .active  (channel)
  );

  trellis_cfg_regbank #(.DEPTH(PT_N), .WIDTH(branch_bitwidth), .AW(addr_bitwidth)) u_pt_bank (
    .clk     (clk),
    .rstb    (rstb),
    .wr_en   (pt_wr),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data[branch_bitwidth-1:0]),
    .swap    (swap),
    .active  (pt_active)
  );

  // Flat pattern storage viewed as [pattern][tap].
  always_comb begin
    for (int ii = 0; ii < num_of_trellis_patterns; ii++)
      for (int kk = 0; kk < trellis_pattern_depth; kk++)
        trellis_patterns[ii][kk] = pt_active[ii*trellis_pattern_depth + kk];
  end

  // Write admission, next-state and pulse generation.
  always_comb begin
    addr_ext     = 32'(cfg_addr);
    ch_wr        = 1'b0;
    pt_wr        = 1'b0;
    nrz_wr       = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    swap         = 1'b0;
    commit_ack_d = 1'b0;
    seqs_valid_d = seqs_valid;
    // The shadow bank is frozen while a commit waits for its frame boundary.
    if (cfg_wr_en && state_q != ARMED) begin
      case (cfg_sel)
        SEL_CHANNEL: ch_wr  = (addr_ext < CH_D_U);
        SEL_PATTERN: pt_wr  = (addr_ext < PT_N_U);
        SEL_NRZ:     nrz_wr = 1'b1;
        default:     ;
      endcase
    end
    cfg_err_d = cfg_wr_en && !(ch_wr || pt_wr || nrz_wr);
    case (state_q)
      IDLE, READY: begin
        if (commit_req) state_d = ARMED;
      end
      ARMED: begin
        if (frame_sync) begin
          swap         = 1'b1;
          commit_ack_d = 1'b1;
          seqs_valid_d = 1'b0;
          cnt_d        = CNT_W'(settle_cycles - 1);
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d      = READY;
          seqs_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, registered status outputs and the NRZ flag pair.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      commit_ack <= 1'b0;
      seqs_valid <= 1'b0;
      cfg_err    <= 1'b0;
      busy       <= 1'b0;
      nrz_shadow <= 1'b0;
      nrz_mode   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      commit_ack <= commit_ack_d;
      seqs_valid <= seqs_valid_d;
      cfg_err    <= cfg_err_d;
      busy       <= (state_d == ARMED) || (state_d == SETTLE);
      if (nrz_wr) nrz_shadow <= cfg_data[0];
      if (swap)   nrz_mode   <= nrz_shadow;
    end
  end

endmodule
